// File: rtl/calc_dp.sv
// calc_dp -- datapath slice: 4 x W register file, two gated read ports,
// 4-function ALU and a registered result with carry/borrow and zero flags.
// No internal sequencing; every cycle is steered by the upstream control unit.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (beats we and s2)
//   in1, in2   external operands (W bits)
//   s1         write-data select: 11 in1, 10 in2, 01 zero, 00 ALU result
//   we, wa     register-file write enable / address
//   raa, rea   port A read address / enable (disabled port reads 0)
//   rab, reb   port B read address / enable
//   c          ALU op: 00 add, 01 sub, 10 and, 11 xor
//   s2         result-register load enable
//   out        registered ALU result
//   cout       registered carry (add) / borrow (sub), 0 for logic ops
//   zero       registered flag, 1 when the loaded result is 0
module calc_dp #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [1:0]   s1,
    input  logic         we,
    input  logic [1:0]   wa,
    input  logic [1:0]   raa,
    input  logic         rea,
    input  logic [1:0]   rab,
    input  logic         reb,
    input  logic [1:0]   c,
    input  logic         s2,
    output logic [W-1:0] out,
    output logic         cout,
    output logic         zero
);

    logic [W-1:0] r_rf [4];
    logic [W-1:0] r_out;
    logic         r_cout;
    logic         r_zero;

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_wd;
    logic [W:0]   w_sum;
    logic [W:0]   w_diff;
    logic [W-1:0] w_res;
    logic         w_cout;

    // Combinational reads of the current (pre-write) contents.
    always_comb begin
        w_a = rea ? r_rf[raa] : '0;
        w_b = reb ? r_rf[rab] : '0;
    end

    always_comb begin
        w_sum  = {1'b0, w_a} + {1'b0, w_b};
        // A + ~B + 1: bit W is the carry-out, i.e. 1 when A >= B, so the
        // borrow is its complement.
        w_diff = {1'b0, w_a} + {1'b0, ~w_b} + {{W{1'b0}}, 1'b1};
        w_res  = '0;
        w_cout = 1'b0;
        unique case (c)
            2'b00: begin
                w_res  = w_sum[W-1:0];
                w_cout = w_sum[W];
            end
            2'b01: begin
                w_res  = w_diff[W-1:0];
                w_cout = ~w_diff[W];
            end
            2'b10: w_res = w_a & w_b;
            2'b11: w_res = w_a ^ w_b;
        endcase
    end

    always_comb begin
        w_wd = '0;
        unique case (s1)
            2'b11: w_wd = in1;
            2'b10: w_wd = in2;
            2'b01: w_wd = '0;
            2'b00: w_wd = w_res;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
        end else if (we) begin
            r_rf[wa] <= w_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= '0;
            r_cout <= 1'b0;
            r_zero <= 1'b1;
        end else if (s2) begin
            r_out  <= w_res;
            r_cout <= w_cout;
            r_zero <= (w_res == '0);
        end
    end

    assign out  = r_out;
    assign cout = r_cout;
    assign zero = r_zero;

endmodule
